// File: rtl/common_pkg.sv
// Shared Wishbone sizing and the SPI command opcode set for the SPI-to-Wishbone master.
package common_pkg;

    localparam int WB_ADDR_WIDTH = 20;
    localparam int DATA_WIDTH    = 8;

    typedef enum logic [3:0] {
        READ_AT    = 4'h4,
        READ_NEXT  = 4'h5,
        WRITE_AT   = 4'h8,
        WRITE_NEXT = 4'h9
    } spi_opcode_t;

endpackage

// File: rtl/spi_cmd_wb_master_if.sv
// Wishbone B4 pipelined single-master bus bundle.
interface spi_cmd_wb_master_if #(
    parameter int AW = common_pkg::WB_ADDR_WIDTH,
    parameter int DW = common_pkg::DATA_WIDTH
);
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    logic          we;
    logic          cyc;
    logic          stb;
    logic          stall;
    logic          ack;

    modport master (
        output addr, wdata, we, cyc, stb,
        input  rdata, stall, ack
    );

    modport slave (
        input  addr, wdata, we, cyc, stb,
        output rdata, stall, ack
    );
endinterface

// File: rtl/spi_cmd_wb_master.sv
// Parses SPI host command bytes and issues single Wishbone reads/writes; one FSM does both.
// Optional bus timeout is compiled in with `define SPI_WB_TIMEOUT_EN.
module spi_cmd_wb_master
    import common_pkg::*;
#(
    parameter int ADDR_WIDTH = WB_ADDR_WIDTH
`ifdef SPI_WB_TIMEOUT_EN
    , parameter int TIMEOUT_CYCLES = 255
`endif
) (
    input  logic                  wb_clock_i,
    input  logic                  wb_reset_i,
    input  logic                  rx_start_i,
    input  logic                  rx_valid_i,
    input  logic [7:0]            rx_data_i,
    output logic [DATA_WIDTH-1:0] tx_data_o,
    output logic                  busy_o,
    output logic                  overrun_o,
    output logic                  err_o,
    spi_cmd_wb_master_if.master   wb
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD_DONE,
        S_ADDR_HI,
        S_DATA,
        S_ISSUE,
        S_WAIT_ACK,
        S_DISCARD
    } state_t;

    state_t                  state_q, state_d, parse_st;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [ADDR_WIDTH-1:0]   cur_q, cur_d;
    logic [ADDR_WIDTH-1:0]   addr_inc;
    logic [19:0]             cur_ext;
    logic                    we_q, we_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]   tx_q, tx_d;
    logic                    err_q, err_d;
    logic                    overrun_q;
    logic                    busy;
    logic                    tmo_hit;

    assign busy     = (state_q == S_ISSUE) || (state_q == S_WAIT_ACK);
    assign addr_inc = addr_q + ADDR_WIDTH'(1);

`ifdef SPI_WB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_q;

    always_ff @(posedge wb_clock_i) begin
        if (wb_reset_i || !busy) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_q + TW'(1);
        end
    end

    // Last cycle of the allowed window with still no ack: abandon the cycle.
    assign tmo_hit = busy && !wb.ack && (tmo_q == TW'(TIMEOUT_CYCLES - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    // NOTE: every variable gets its default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d  = state_q;
        cur_ext  = 20'(cur_q);
        addr_d   = addr_q;
        we_d     = we_q;
        wdata_d  = wdata_q;
        tx_d     = tx_q;
        err_d    = err_q;
        parse_st = rx_start_i ? S_IDLE : state_q;

        if (rx_start_i) begin
            err_d = 1'b0;
        end

        case (state_q)
            S_ISSUE: begin
                if (!wb.stall) begin
                    if (wb.ack) begin
                        state_d = S_IDLE;
                        addr_d  = cur_q;
                        if (!we_q) tx_d = wb.rdata;
                    end else begin
                        state_d = S_WAIT_ACK;
                    end
                end
            end
            S_WAIT_ACK: begin
                if (wb.ack) begin
                    state_d = S_IDLE;
                    addr_d  = cur_q;
                    if (!we_q) tx_d = wb.rdata;
                end
            end
            default: begin
                // A frame start aborts parsing; a byte in the same cycle is the new command.
                state_d = parse_st;
                if (rx_valid_i) begin
                    case (parse_st)
                        S_IDLE: begin
                            case (spi_opcode_t'(rx_data_i[7:4]))
                                READ_AT: begin
                                    we_d    = 1'b0;
                                    cur_ext = {rx_data_i[3:0], 16'h0000};
                                    state_d = S_CMD_DONE;
                                end
                                WRITE_AT: begin
                                    we_d    = 1'b1;
                                    cur_ext = {rx_data_i[3:0], 16'h0000};
                                    state_d = S_CMD_DONE;
                                end
                                READ_NEXT: begin
                                    we_d    = 1'b0;
                                    cur_ext = 20'(addr_inc);
                                    state_d = S_ISSUE;
                                end
                                WRITE_NEXT: begin
                                    we_d    = 1'b1;
                                    cur_ext = 20'(addr_inc);
                                    state_d = S_DATA;
                                end
                                default: state_d = S_DISCARD;
                            endcase
                        end
                        S_CMD_DONE: begin
                            cur_ext[15:8] = rx_data_i;
                            state_d       = S_ADDR_HI;
                        end
                        S_ADDR_HI: begin
                            cur_ext[7:0] = rx_data_i;
                            state_d      = we_q ? S_DATA : S_ISSUE;
                        end
                        S_DATA: begin
                            wdata_d = rx_data_i;
                            state_d = S_ISSUE;
                        end
                        default: ;
                    endcase
                end
            end
        endcase

        if (tmo_hit) begin
            state_d = S_IDLE;
            err_d   = 1'b1;
        end

        cur_d = cur_ext[ADDR_WIDTH-1:0];
    end

    // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
    always_ff @(posedge wb_clock_i) begin
        if (wb_reset_i) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            cur_q     <= '0;
            we_q      <= 1'b0;
            wdata_q   <= '0;
            tx_q      <= '0;
            err_q     <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            cur_q     <= cur_d;
            we_q      <= we_d;
            wdata_q   <= wdata_d;
            tx_q      <= tx_d;
            err_q     <= err_d;
            overrun_q <= busy && rx_valid_i;
        end
    end

    assign wb.addr   = cur_q;
    assign wb.wdata  = wdata_q;
    assign wb.we     = we_q;
    assign wb.cyc    = busy;
    assign wb.stb    = (state_q == S_ISSUE);
    assign tx_data_o = tx_q;
    assign busy_o    = busy;
    assign overrun_o = overrun_q;
    assign err_o     = err_q;

endmodule
